load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to a word-organised data memory over
// a req/gnt + rvalid handshake, with byte/half lane steering and load extension.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            lsu_busy,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;

  logic              op;
  logic              bad;
  logic [3:0]        st_be;
  logic [XLEN-1:0]   st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;

  assign op = mem_read | mem_write;

  // A simultaneous read and write request is a store, so legality follows mem_write.
  always_comb begin
    bad = 1'b0;
    if (funct3[1:0] == 2'b01 && addr[0])               bad = 1'b1;
    if (funct3 == 3'b010 && addr[1:0] != 2'b00)        bad = 1'b1;
    if (mem_write && !(funct3 inside {3'b000, 3'b001, 3'b010}))      bad = 1'b1;
    if (!mem_write && (funct3 inside {3'b011, 3'b110, 3'b111}))      bad = 1'b1;
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr_q[1:0];
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // NOTE: every output and next-state value gets a default before the case;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    load_data_d = load_data_q;
    lsu_busy    = 1'b0;
    misaligned  = 1'b0;
    load_valid  = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_be     = 4'b0000;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        // rst_n gating keeps the combinational IDLE outputs low while reset is held.
        if (op && rst_n) begin
          if (bad) begin
            misaligned = 1'b1;
          end else begin
            lsu_busy   = 1'b1;
            addr_d     = addr;
            wdata_d    = wdata;
            funct3_d   = funct3;
            is_store_d = mem_write;
            state_d    = S_REQ;
          end
        end
      end
      S_REQ: begin
        dmem_req  = 1'b1;
        lsu_busy  = 1'b1;
        dmem_addr = {addr_q[XLEN-1:2], 2'b00};
        dmem_we   = is_store_q;
        if (is_store_q) begin
          dmem_be    = st_be;
          dmem_wdata = st_wdata;
        end else begin
          dmem_be    = 4'b1111;
        end
        if (dmem_gnt) state_d = is_store_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        lsu_busy = 1'b1;
        if (dmem_rvalid) begin
          load_data_d = ld_ext;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        load_valid = ~is_store_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= 3'b000;
      is_store_q  <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected memory
// requests and completions, and a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        lsu_busy, load_valid, misaligned;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .lsu_busy(lsu_busy), .load_valid(load_valid), .load_data(load_data),
    .misaligned(misaligned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          busy;
    logic        is_load;
    logic [31:0] data;
  } txn_t;

  req_t        exp_req[$];
  txn_t        exp_txn[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [31:0] last_load = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the bus while a request is up and the completion in DONE.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (dmem_req) begin
        if (exp_req.size() == 0) begin
          check("unexpected_req", 32'(dmem_req), 32'h0);
        end else begin
          check("req_addr", dmem_addr, exp_req[0].addr);
          check("req_we", 32'(dmem_we), 32'(exp_req[0].we));
          check("req_be", 32'(dmem_be), 32'(exp_req[0].be));
          if (exp_req[0].we) check("req_wdata", dmem_wdata, exp_req[0].wdata);
          if (dmem_gnt) void'(exp_req.pop_front());
        end
      end else begin
        check("bus_quiet", 32'({dmem_we, |dmem_be, |dmem_addr, |dmem_wdata}), 32'h0);
      end
      if (lsu_busy) begin
        busy_cnt++;
        check("misaligned_while_busy", 32'(misaligned), 32'h0);
      end else if (busy_cnt > 0) begin
        if (exp_txn.size() == 0) begin
          check("unexpected_done", 32'(busy_cnt), 32'h0);
        end else begin
          check("busy_cycles", 32'(busy_cnt), 32'(exp_txn[0].busy));
          check("load_valid_done", 32'(load_valid), 32'(exp_txn[0].is_load));
          check("load_data", load_data, exp_txn[0].data);
          void'(exp_txn.pop_front());
        end
        busy_cnt = 0;
      end else begin
        check("load_valid_idle", 32'(load_valid), 32'h0);
      end
    end
  end

  // Driver: called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gw, input int rw, input logic [31:0] rdat,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_load);
    req_t r;
    txn_t t;
    r.addr = e_addr; r.we = wr; r.be = e_be; r.wdata = e_wdata;
    exp_req.push_back(r);
    t.is_load = ~wr;
    t.busy    = wr ? (2 + gw) : (3 + gw + rw);
    if (!wr) last_load = e_load;
    t.data    = last_load;
    exp_txn.push_back(t);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (gw) begin @(posedge clk); #1; end
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    if (!wr) begin
      repeat (rw) begin @(posedge clk); #1; end
      dmem_rvalid = 1'b1; dmem_rdata = rdat;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
    end
    // In DONE a new request must be ignored.
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0;
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  task automatic bad_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'h1111_2222;
    @(negedge clk);
    check("bad_misaligned", 32'(misaligned), 32'h1);
    check("bad_no_req", 32'(dmem_req), 32'h0);
    check("bad_not_busy", 32'(lsu_busy), 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0; wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #3;
    check("rst_busy", 32'(lsu_busy), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_be", 32'(dmem_be), 32'h0);
    check("rst_misaligned", 32'(misaligned), 32'h0);
    check("rst_load_valid", 32'(load_valid), 32'h0);
    check("rst_load_data", load_data, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    //     rd wr f3      addr        wdata         gw rw rdata         e_addr      e_be     e_wdata       e_load
    access(0, 1, 3'b010, 32'h100,    32'hDEADBEEF, 0, 0, 32'h0,        32'h100,    4'b1111, 32'hDEADBEEF, 32'h0);
    access(1, 0, 3'b000, 32'h203,    32'h0,        0, 0, 32'h80FFFFFF, 32'h200,    4'b1111, 32'h0,        32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h203,    32'h0,        0, 0, 32'h80FFFFFF, 32'h200,    4'b1111, 32'h0,        32'h00000080);
    access(0, 1, 3'b001, 32'h12,     32'h0000ABCD, 0, 0, 32'h0,        32'h10,     4'b1100, 32'hABCDABCD, 32'h0);
    bad_access(1, 0, 3'b010, 32'h101);
    access(1, 0, 3'b001, 32'h102,    32'h0,        2, 1, 32'h92340001, 32'h100,    4'b1111, 32'h0,        32'hFFFF9234);
    access(0, 1, 3'b000, 32'h7,      32'h123456A5, 0, 0, 32'h0,        32'h4,      4'b1000, 32'hA5A5A5A5, 32'h0);
    access(1, 1, 3'b010, 32'h20,     32'h0BADF00D, 1, 0, 32'h0,        32'h20,     4'b1111, 32'h0BADF00D, 32'h0);
    access(1, 0, 3'b010, 32'h40,     32'h0,        0, 0, 32'hCAFEBABE, 32'h40,     4'b1111, 32'h0,        32'hCAFEBABE);
    bad_access(0, 1, 3'b100, 32'h0);
    bad_access(1, 0, 3'b011, 32'h0);
    bad_access(1, 0, 3'b001, 32'h3);
    bad_access(0, 1, 3'b010, 32'h2);
    access(1, 0, 3'b101, 32'h100,    32'h0,        0, 0, 32'h0001F00D, 32'h100,    4'b1111, 32'h0,        32'h0000F00D);
    access(1, 0, 3'b000, 32'h1,      32'h0,        0, 0, 32'h00007F00, 32'h0,      4'b1111, 32'h0,        32'h0000007F);
    access(0, 1, 3'b010, 32'h44,     32'h11223344, 0, 2, 32'h0,        32'h44,     4'b1111, 32'h11223344, 32'h0);

    // Reset while waiting for read data.
    begin
      req_t r;
      r.addr = 32'h0; r.we = 1'b0; r.be = 4'b1111; r.wdata = 32'h0;
      exp_req.push_back(r);
    end
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0;
    @(posedge clk); #1;
    mem_read = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("wait_rst_req", 32'(dmem_req), 32'h0);
    check("wait_rst_busy", 32'(lsu_busy), 32'h0);
    check("wait_rst_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_load = 32'h0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("spurious_rvalid_load_data", load_data, 32'h0);

    access(1, 0, 3'b010, 32'h8,      32'h0,        0, 0, 32'h01020304, 32'h8,      4'b1111, 32'h0,        32'h01020304);

    repeat (3) @(posedge clk);
    #1;
    check("req_queue_drained", 32'(exp_req.size()), 32'h0);
    check("txn_queue_drained", 32'(exp_txn.size()), 32'h0);
    check("busy_cnt_idle", 32'(busy_cnt), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
